// File: rtl/fourteen_to_one_serializer_fsm.sv
`default_nettype none
// ============================================================================
// Module      : fourteen_to_one_serializer_fsm
// Description : FSM-controlled parallel-to-serial transmitter for the 14-bit
//               ss/data/ready/Ack link. Frames a captured word with
//               active-low ss and shifts it out MSB first. Serial data lags
//               ss by one cycle. After the frame it waits for the receiver's
//               ready and returns a one-cycle Ack. It gives up with a sticky
//               err after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fourteen_to_one_serializer_fsm #(
  parameter int WIDTH   = 14,
  parameter int TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rx_ready,
  output logic             ss,
  output logic             data_out,
  output logic             Ack,
  output logic             busy,
  output logic             done,
  output logic             err
);

  // Bit counter wide enough to hold WIDTH; wait counter wide enough for TIMEOUT.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);
  localparam logic [TMO_W-1:0] LAST_WAIT = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FRAME    = 3'd1,
    TAIL     = 3'd2,
    WAIT_RDY = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [TMO_W-1:0] wait_cnt;

  // Control FSM. All outputs are registered and are computed from the state
  // being entered, so each output lines up with its state without extra logic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      ss        <= 1'b1;
      data_out  <= 1'b0;
      Ack       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Ack and done are single-cycle pulses. Only the WAIT_RDY->ACK step raises them.
      Ack  <= 1'b0;
      done <= 1'b0;

      case (state)
        IDLE: begin
          ss       <= 1'b1;
          data_out <= 1'b0;
          busy     <= 1'b0;
          if (start) begin
            // Capture the word and start a fresh frame. A new frame clears
            // any previous timeout.
            shift_reg <= data_in;
            bit_cnt   <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
            ss        <= 1'b0;
            busy      <= 1'b1;
            state     <= FRAME;
          end
        end

        FRAME: begin
          // Each FRAME cycle launches the next MSB for the following cycle.
          // The last launch (bit 0) therefore lands in TAIL, when ss is
          // already high again.
          data_out  <= shift_reg[WIDTH-1];
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            ss      <= 1'b1;
            state   <= TAIL;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        TAIL: begin
          // Bit 0 is on the line this cycle. The line idles low while waiting.
          data_out <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT_RDY;
        end

        WAIT_RDY: begin
          // rx_ready is only looked at here. Ready wins over timeout in the last wait cycle.
          if (rx_ready) begin
            Ack   <= 1'b1;
            done  <= 1'b1;
            state <= ACK;
          end else if (wait_cnt == LAST_WAIT) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          // Unused or corrupted encodings recover to a quiet idle line.
          ss       <= 1'b1;
          data_out <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fourteen_to_one_serializer_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_fourteen_to_one_serializer_fsm
// Description : Self-checking bench for fourteen_to_one_serializer_fsm.
//               Cycle-accurate vector tables are built from the link timing
//               rules. A behavioural receiver recovers words, and a scoreboard
//               matches them against the words that were started.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fourteen_to_one_serializer_fsm;

  localparam int WIDTH         = 14;
  localparam int TIMEOUT       = 8;
  localparam int TAIL_CYC      = WIDTH + 1;
  localparam int LAST_WAIT_CYC = WIDTH + 1 + TIMEOUT;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic [WIDTH-1:0] data_in  = '0;
  logic             rx_ready = 1'b0;
  logic             ss;
  logic             data_out;
  logic             Ack;
  logic             busy;
  logic             done;
  logic             err;

  fourteen_to_one_serializer_fsm #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .rx_ready (rx_ready),
    .ss       (ss),
    .data_out (data_out),
    .Ack      (Ack),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  // One vector is one cycle: the inputs for that cycle and the outputs
  // expected during it, packed as {ss, data_out, Ack, busy, done, err}.
  typedef struct {
    int               id;
    int               cyc;
    logic             start;
    logic [WIDTH-1:0] data;
    logic             rdy;
    logic             push;
    logic [5:0]       exp;
  } vec_t;

  vec_t             vecs[$];
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] rx_words[$];
  int               checks   = 0;
  int               failures = 0;

  // Behavioural receiver. ss is sampled one cycle before each data bit. The
  // edge on which ss is seen high again, after having been low, closes the word.
  logic             rx_prev_ss;
  logic [WIDTH-1:0] rx_shift;

  always @(posedge clock) begin
    if (reset) begin
      rx_prev_ss <= 1'b1;
      rx_shift   <= '0;
    end else begin
      rx_prev_ss <= ss;
      if (!rx_prev_ss) begin
        rx_shift <= {rx_shift[WIDTH-2:0], data_out};
        if (ss) rx_words.push_back({rx_shift[WIDTH-2:0], data_out});
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every word the receiver has closed against the oldest started word.
  task automatic drain();
    logic [WIDTH-1:0] got;
    while (rx_words.size() > 0) begin
      got = rx_words.pop_front();
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_frame: got unexpected word %04h expected none", got);
      end else begin
        check("rx_frame word", 32'(got), 32'(sb.pop_front()));
      end
    end
  endtask

  // Build the cycle table for one frame, with cycle 0 as the accepting cycle.
  // rdy_cyc < 0 means the receiver never answers, so the frame times out.
  task automatic add_frame(input int id, input logic [WIDTH-1:0] word,
                           input logic [WIDTH-1:0] other, input int rdy_cyc,
                           input int start_until, input int junk_cyc,
                           input bit noise, input logic err0, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      vec_t v;
      logic e_ss, e_do, e_ack, e_busy, e_err;
      v.id    = id;
      v.cyc   = c;
      v.start = (c <= start_until) || (c == junk_cyc);
      v.data  = (c == 0) ? word : other;
      v.rdy   = (c == rdy_cyc) || (noise && (c == 8 || c == TAIL_CYC));
      v.push  = (c == 0);
      e_ss    = !(c >= 1 && c <= WIDTH);
      e_do    = (c >= 2 && c <= WIDTH + 1) ? word[WIDTH + 1 - c] : 1'b0;
      if (rdy_cyc >= 0) begin
        e_ack  = (c == rdy_cyc + 1);
        e_busy = (c >= 1) && (c <= rdy_cyc + 1);
        e_err  = (c == 0) ? err0 : 1'b0;
      end else begin
        e_ack  = 1'b0;
        e_busy = (c >= 1) && (c <= LAST_WAIT_CYC);
        e_err  = (c == 0) ? err0 : (c > LAST_WAIT_CYC);
      end
      v.exp = {e_ss, e_do, e_ack, e_busy, e_ack, e_err};
      vecs.push_back(v);
    end
  endtask

  task automatic run_vectors();
    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      start    = vecs[i].start;
      data_in  = vecs[i].data;
      rx_ready = vecs[i].rdy;
      if (vecs[i].push) sb.push_back(vecs[i].data);
      check($sformatf("t%0d cyc%0d {ss,dout,ack,busy,done,err}", vecs[i].id, vecs[i].cyc),
            32'({ss, data_out, Ack, busy, done, err}), 32'(vecs[i].exp));
      drain();
    end
    vecs.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with start asserted at the same time: reset must win.
    reset   = 1'b1;
    start   = 1'b1;
    data_in = 14'h3333;
    repeat (3) @(posedge clock);
    #1;
    check("reset state", 32'({ss, data_out, Ack, busy, done, err}), 32'(6'b100000));
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle after reset", 32'({ss, data_out, Ack, busy, done, err}), 32'(6'b100000));

    // Single frame, with the receiver answering 3 cycles after TAIL.
    add_frame(1, 14'h2A5C, 14'h0000, TAIL_CYC + 3, 0, -1, 1'b0, 1'b0, 22);
    run_vectors();

    // Back-to-back with start held: the second word is accepted the cycle busy drops.
    add_frame(2, 14'h3FFF, 14'h3FFF, TAIL_CYC + 1, 17, -1, 1'b0, 1'b0, 18);
    add_frame(3, 14'h0001, 14'h0001, TAIL_CYC + 1, 16, -1, 1'b0, 1'b0, 21);
    run_vectors();

    // Start pulse during busy is ignored. Early ready in FRAME/TAIL is ignored.
    add_frame(4, 14'h2A5C, 14'h0F0F, TAIL_CYC + 1, 0, 5, 1'b1, 1'b0, 24);
    run_vectors();

    // Timeout: no ready ever. The next accepted start clears err.
    add_frame(5, 14'h0ABC, 14'h0000, -1, 0, -1, 1'b0, 1'b0, 28);
    add_frame(6, 14'h1555, 14'h0000, TAIL_CYC + 1, 0, -1, 1'b0, 1'b1, 19);
    run_vectors();

    // Reset in cycle 7 of a frame takes effect before the next edge.
    add_frame(7, 14'h2A5C, 14'h0000, TAIL_CYC + 1, 0, -1, 1'b0, 1'b0, 8);
    run_vectors();
    #3;
    reset = 1'b1;
    #1;
    check("async reset mid-frame", 32'({ss, data_out, Ack, busy, done, err}), 32'(6'b100000));
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("held reset", 32'({ss, data_out, Ack, busy, done, err}), 32'(6'b100000));

    // Fresh frame after reset.
    add_frame(8, 14'h1234, 14'h0000, TAIL_CYC + 1, 0, -1, 1'b0, 1'b0, 20);
    run_vectors();

    repeat (2) @(posedge clock);
    #1;
    drain();
    check("scoreboard empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fourteen_to_one_serializer_fsm.md
Name: fourteen_to_one_serializer_fsm

Overview:
- FSM-controlled parallel-to-serial transmitter for the 14-bit ss/data/ready/Ack link. It is the sending end for the link's existing FSM-based deserializer.
- Accepts a parallel word with a start strobe and frames it with active-low ss, sending MSB first.
- Waits for the receiver's ready, then returns a one-cycle Ack so the receiver re-arms.

Parameters:
WIDTH, 14, bits per frame; the counter is sized to hold WIDTH.
TIMEOUT, 255, maximum cycles spent in WAIT_RDY before the frame is aborted with err.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request to send; accepted only when busy=0
data_in  input  WIDTH  parallel word; captured on the accepting edge
rx_ready  input  1  receiver's ready output
ss  output  1  frame select, active low, registered
data_out  output  1  serial data, registered
Ack  output  1  one-cycle acknowledge to the receiver, registered
busy  output  1  high from the cycle after acceptance until the transmitter returns to IDLE
done  output  1  one-cycle pulse, coincident with Ack
err  output  1  sticky timeout flag; cleared by reset or by the next accepted start

Behaviour:
- Reset, asynchronous and effective immediately, including mid-frame: state=IDLE, ss=1, data_out=0, Ack=0, busy=0, done=0, err=0, shift register=0, counter=0.
- Cycle numbering: cycle 0 is the cycle in which start=1 and busy=0 are sampled. On that edge data_in is loaded into the shift register, err is cleared and the state becomes FRAME.
- FRAME (cycles 1..WIDTH):
  - ss=0 throughout.
  - data_out shows bit WIDTH-1 in cycle 2, bit WIDTH-2 in cycle 3, and so on; the shift is MSB first.
  - data_out=0 in cycle 1.
  - The counter counts WIDTH cycles.
- TAIL (cycle WIDTH+1): ss=1 and data_out=bit 0. This one-cycle data lag against ss is required: the receiver samples ss one cycle before it samples each data bit, and it also samples on the edge where ss rises.
- WAIT_RDY (from cycle WIDTH+2):
  - ss=1, data_out=0.
  - If rx_ready=1 is sampled, go to ACK.
  - If TIMEOUT cycles pass without rx_ready, set err=1 and go to IDLE with no Ack and no done.
- ACK: Ack=1 and done=1 for exactly one cycle, then IDLE.
- busy=1 in every non-IDLE state. busy is registered and its value follows the state.
- start while busy=1 is ignored. Such a request is not queued, and data_in is not re-captured.
- Normal back-to-back timing:
  - rx_ready goes high in cycle WIDTH+2.
  - Ack is high in cycle WIDTH+3.
  - busy=0 in cycle WIDTH+4, and the earliest next acceptance is in that cycle.
  - ss is therefore high for at least 3 cycles between frames.
- rx_ready=1 in TAIL or FRAME is ignored; it is only sampled in WAIT_RDY.
- start=1 together with reset: reset wins.
- An X or undefined state decodes to IDLE.

Test Plan:
- Single frame: start with data_in=14'h2A5C.
  - ss low for exactly cycles 1..14.
  - data_out sequence over cycles 2..15 is 1,0,1,0,1,0,0,1,0,1,1,1,0,0.
  - A behavioural receiver sampling per the ss/data rules recovers 14'h2A5C.
- Handshake: rx_ready asserted 3 cycles after TAIL.
  - Ack=1 and done=1 for exactly one cycle, in the cycle after rx_ready is first sampled high.
  - busy falls in the following cycle.
- Back-to-back: words 14'h3FFF then 14'h0001, with start held high continuously.
  - Second frame's ss falls 2 cycles after Ack.
  - No start accepted while busy.
  - Both words recovered intact.
- Timeout: never assert rx_ready, TIMEOUT=8.
  - err=1 after 8 WAIT_RDY cycles, Ack never asserted, busy=0 afterwards.
  - Next start clears err.
- Reset mid-frame: assert reset at cycle 7.
  - ss=1, data_out=0, busy=0 immediately, before the next clock edge.
  - After release, a fresh frame of 14'h1234 transmits correctly.
- Start during busy: pulse start with data_in=14'h0F0F in cycle 5 of a 14'h2A5C frame → transmitted bits unchanged and no second frame follows.
